// File: rtl/peripheral_msi_bus_master_if.sv
// peripheral_msi_bus_master_if
// Bundles the three channels of the MSI bus master:
//   request stream  : req_valid/req_ready, req_addr, req_we, req_wdata
//   response stream : rsp_valid/rsp_ready, rsp_rdata, rsp_write
//   peripheral bus  : per_addr, per_din, per_en, per_we (out), per_dout (in)
// Modports:
//   master : the bus-master block
//            (accepts requests, returns responses, drives the peripheral bus)
//   slave  : the other side (request source, response sink, peripheral)
interface peripheral_msi_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [13:0] req_addr;
  logic [1:0]  req_we;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_write;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (
    input  req_valid, req_addr, req_we, req_wdata, rsp_ready, per_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_write,
           per_addr, per_din, per_en, per_we
  );

  modport slave (
    output req_valid, req_addr, req_we, req_wdata, rsp_ready, per_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_write,
           per_addr, per_din, per_en, per_we
  );
endinterface

// File: rtl/peripheral_msi_bus_master.sv
// peripheral_msi_bus_master
// Turns a valid/ready request stream into single-cycle MSI peripheral bus
// accesses and returns exactly one response per request, strictly in order.
// Ports:
//   mclk, puc_rst : clock, asynchronous active-high reset
//   bus           : peripheral_msi_bus_master_if.master (request, response and
//                   peripheral bus signals)
//   busy          : FSM not idle, or request FIFO not empty
// Parameters:
//   RD_LATENCY    : cycles after the per_en cycle at which per_dout is sampled (0..3)
//   FIFO_DEPTH    : request FIFO depth (power of two, >= 2)
// Build option:
//   PERIPHERAL_MSI_MASTER_FIFO_EN : when defined, requests are queued in a
//   FIFO_DEPTH-entry FIFO; otherwise requests load the bus registers directly.
module peripheral_msi_bus_master #(
  parameter int RD_LATENCY = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               mclk,
  input  logic                               puc_rst,
  peripheral_msi_bus_master_if.master        bus,
  output logic                               busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  // Index of the last WAIT cycle; unused when RD_LATENCY is 0.
  localparam logic [1:0] WAIT_LAST = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;
  // An illegal parameter set never accepts a request.
  localparam bit CFG_OK = (RD_LATENCY >= 0) && (RD_LATENCY <= 3) && (FIFO_DEPTH >= 2);

  state_t      state_q, state_d;
  logic [13:0] per_addr_q, per_addr_d;
  logic [15:0] per_din_q, per_din_d;
  logic [1:0]  per_we_q, per_we_d;
  logic        per_en_q, per_en_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_write_q, rsp_write_d;
  // Low during reset and high from the first edge after release, so that
  // req_ready stays low while puc_rst is asserted.
  logic        ready_en_q, ready_en_d;

  // Request seen by the IDLE state (FIFO head or the live request).
  logic        take;
  logic [13:0] src_addr;
  logic [1:0]  src_we;
  logic [15:0] src_wdata;
  logic        fifo_empty;

`ifdef PERIPHERAL_MSI_MASTER_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 14 + 2 + 16;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, fifo_full;

  assign fifo_full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty    = (count_q == '0);
  assign bus.req_ready = ready_en_q && !fifo_full && CFG_OK;
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (state_q == IDLE) && !fifo_empty;
  assign take          = pop;
  // Head is read combinationally so IDLE can pop the edge after a push.
  assign {src_addr, src_we, src_wdata} = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.req_addr, bus.req_we, bus.req_wdata};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: only entries behind a valid count are read.
  always_ff @(posedge mclk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  assign bus.req_ready = ready_en_q && (state_q == IDLE) && CFG_OK;
  assign take          = bus.req_valid && bus.req_ready;
  assign src_addr      = bus.req_addr;
  assign src_we        = bus.req_we;
  assign src_wdata     = bus.req_wdata;
  assign fifo_empty    = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    per_addr_d  = per_addr_q;
    per_din_d   = per_din_q;
    per_we_d    = 2'b00;   // write enables live for the ACCESS cycle only
    per_en_d    = 1'b0;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_write_d = rsp_write_q;
    ready_en_d  = 1'b1;
    case (state_q)
      IDLE: begin
        if (take) begin
          per_addr_d = src_addr;
          per_din_d  = (src_we == 2'b00) ? 16'h0000 : src_wdata;
          per_we_d   = src_we;
          per_en_d   = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = 2'd0;
        if (per_we_q != 2'b00) begin
          rsp_rdata_d = 16'h0000;
          rsp_write_d = 1'b1;
          state_d     = RESP;
        end else if (RD_LATENCY == 0) begin
          rsp_rdata_d = bus.per_dout;
          rsp_write_d = 1'b0;
          state_d     = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          rsp_rdata_d = bus.per_dout;
          rsp_write_d = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          per_addr_d  = 14'h0000;
          per_din_d   = 16'h0000;
          rsp_rdata_d = 16'h0000;
          rsp_write_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q     <= IDLE;
      per_addr_q  <= '0;
      per_din_q   <= '0;
      per_we_q    <= '0;
      per_en_q    <= 1'b0;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_write_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_addr_q  <= per_addr_d;
      per_din_q   <= per_din_d;
      per_we_q    <= per_we_d;
      per_en_q    <= per_en_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_write_q <= rsp_write_d;
      ready_en_q  <= ready_en_d;
    end
  end

  assign bus.per_addr  = per_addr_q;
  assign bus.per_din   = per_din_q;
  assign bus.per_en    = per_en_q;
  assign bus.per_we    = per_we_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_write = rsp_write_q;
  assign busy          = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_peripheral_msi_bus_master.sv
// tb_peripheral_msi_bus_master
// Two masters share one stimulus set: u_dut0 with RD_LATENCY=0 and u_dut2 with
// RD_LATENCY=2. 'sel' routes req_valid to one of them and picks which one's
// outputs are observed. Table-driven transactions plus hand-written sequences
// for backpressure, FIFO fill and reset during an access.
module tb_peripheral_msi_bus_master;
  logic        mclk      = 1'b0;
  logic        puc_rst   = 1'b1;
  logic        sel       = 1'b0;
  logic        req_valid = 1'b0;
  logic [13:0] req_addr  = '0;
  logic [1:0]  req_we    = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic [15:0] per_dout  = '0;
  logic        busy0, busy2;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef PERIPHERAL_MSI_MASTER_FIFO_EN
  localparam int ACC_LAT = 1;
`else
  localparam int ACC_LAT = 0;
`endif

  always #5 mclk = ~mclk;

  peripheral_msi_bus_master_if bus0 ();
  peripheral_msi_bus_master_if bus2 ();

  peripheral_msi_bus_master #(.RD_LATENCY(0), .FIFO_DEPTH(4)) u_dut0 (
    .mclk(mclk), .puc_rst(puc_rst), .bus(bus0), .busy(busy0));
  peripheral_msi_bus_master #(.RD_LATENCY(2), .FIFO_DEPTH(4)) u_dut2 (
    .mclk(mclk), .puc_rst(puc_rst), .bus(bus2), .busy(busy2));

  assign bus0.req_valid = req_valid && !sel;
  assign bus2.req_valid = req_valid && sel;
  assign bus0.req_addr  = req_addr;
  assign bus2.req_addr  = req_addr;
  assign bus0.req_we    = req_we;
  assign bus2.req_we    = req_we;
  assign bus0.req_wdata = req_wdata;
  assign bus2.req_wdata = req_wdata;
  assign bus0.rsp_ready = rsp_ready;
  assign bus2.rsp_ready = rsp_ready;
  assign bus0.per_dout  = per_dout;
  assign bus2.per_dout  = per_dout;

  logic        c_req_ready, c_rsp_valid, c_rsp_write, c_per_en, c_busy;
  logic [15:0] c_rsp_rdata, c_per_din;
  logic [13:0] c_per_addr;
  logic [1:0]  c_per_we;
  assign c_req_ready = sel ? bus2.req_ready : bus0.req_ready;
  assign c_rsp_valid = sel ? bus2.rsp_valid : bus0.rsp_valid;
  assign c_rsp_write = sel ? bus2.rsp_write : bus0.rsp_write;
  assign c_rsp_rdata = sel ? bus2.rsp_rdata : bus0.rsp_rdata;
  assign c_per_en    = sel ? bus2.per_en    : bus0.per_en;
  assign c_per_addr  = sel ? bus2.per_addr  : bus0.per_addr;
  assign c_per_din   = sel ? bus2.per_din   : bus0.per_din;
  assign c_per_we    = sel ? bus2.per_we    : bus0.per_we;
  assign c_busy      = sel ? busy2          : busy0;

  typedef struct {
    logic        sel;
    logic [13:0] addr;
    logic [1:0]  we;
    logic [15:0] wdata;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] exp_rdata;
    logic        exp_write;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];
  vec_t tmp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for req_ready at a negedge; returns at the negedge after
  // the accept edge with req_valid low.
  task automatic push_only(input logic [13:0] a, input logic [1:0] w, input logic [15:0] d);
    int budget;
    budget = 20;
    req_addr = a; req_we = w; req_wdata = d; req_valid = 1'b1;
    while (!c_req_ready && budget > 0) begin
      @(negedge mclk);
      budget--;
    end
    check("accept in time", budget > 0, 1);
    @(negedge mclk);
    req_valid = 1'b0;
  endtask

  // One complete transaction with hand-computed expectations from the record.
  task automatic run_txn(input int id, input vec_t v);
    int lat;
    lat = (v.we != 2'b00) ? 0 : (v.sel ? 2 : 0);
    sel = v.sel;
    rsp_ready = 1'b1;
    per_dout = 16'hDEAD;
    push_only(v.addr, v.we, v.wdata);
    repeat (ACC_LAT) @(negedge mclk);
    check("per_en in access", c_per_en, 1);
    check("per_addr", c_per_addr, v.addr);
    check("per_din", c_per_din, (v.we == 2'b00) ? 16'h0000 : v.wdata);
    check("per_we", c_per_we, v.we);
    check("busy in access", c_busy, 1);
    check("no early rsp", c_rsp_valid, 0);
    per_dout = v.d0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge mclk);
      per_dout = (i == 1) ? v.d1 : v.d2;
      check("per_en low in wait", c_per_en, 0);
      check("per_we low in wait", c_per_we, 0);
      check("per_addr held in wait", c_per_addr, v.addr);
      check("no rsp in wait", c_rsp_valid, 0);
    end
    @(negedge mclk);
    check("rsp_valid", c_rsp_valid, 1);
    check("rsp_rdata", c_rsp_rdata, v.exp_rdata);
    check("rsp_write", c_rsp_write, v.exp_write);
    check("per_en single cycle", c_per_en, 0);
    $display("[TB] txn %0d dut=%0d addr=%h we=%b wdata=%h -> rdata=%h write=%0d",
             id, v.sel ? 2 : 0, v.addr, v.we, v.wdata, c_rsp_rdata, c_rsp_write);
    @(negedge mclk);
    check("rsp consumed", c_rsp_valid, 0);
    check("idle after rsp", c_busy, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int budget;
    int seen;
    int pe_cnt;
    int rsp_cnt;

    vecs[0] = '{1'b0, 14'h0040, 2'b11, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[1] = '{1'b0, 14'h0041, 2'b00, 16'h5555, 16'hBEEF, 16'h0000, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 14'h0100, 2'b00, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h3333, 1'b0};
    vecs[3] = '{1'b0, 14'h0042, 2'b01, 16'h00A5, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[4] = '{1'b0, 14'h0043, 2'b10, 16'hA500, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[5] = '{1'b0, 14'h0042, 2'b00, 16'h0000, 16'h00A5, 16'h0000, 16'h0000, 16'h00A5, 1'b0};
    vecs[6] = '{1'b1, 14'h3FFF, 2'b11, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[7] = '{1'b1, 14'h0000, 2'b00, 16'h0000, 16'hAAAA, 16'h5555, 16'h0F0F, 16'h0F0F, 1'b0};
    vecs[8] = '{1'b0, 14'h2AAA, 2'b00, 16'h0000, 16'h1357, 16'h0000, 16'h0000, 16'h1357, 1'b0};

    // Reset state
    repeat (2) @(negedge mclk);
    check("rst per_en dut0", bus0.per_en, 0);
    check("rst per_en dut2", bus2.per_en, 0);
    check("rst per_we dut0", bus0.per_we, 0);
    check("rst per_addr dut0", bus0.per_addr, 0);
    check("rst per_din dut0", bus0.per_din, 0);
    check("rst rsp_valid dut0", bus0.rsp_valid, 0);
    check("rst rsp_rdata dut0", bus0.rsp_rdata, 0);
    check("rst rsp_write dut0", bus0.rsp_write, 0);
    check("rst busy dut0", busy0, 0);
    check("rst busy dut2", busy2, 0);
    check("rst req_ready dut0", bus0.req_ready, 0);
    check("rst req_ready dut2", bus2.req_ready, 0);
    puc_rst = 1'b0;
    #1;
    check("req_ready low before first edge", bus0.req_ready, 0);
    @(negedge mclk);
    check("req_ready after release dut0", bus0.req_ready, 1);
    check("req_ready after release dut2", bus2.req_ready, 1);

    // Table-driven transactions
    for (int i = 0; i < NV; i++) begin
      run_txn(i, vecs[i]);
    end

    // Response backpressure: response held stable, no new bus access
    sel = 1'b0;
    rsp_ready = 1'b0;
    push_only(14'h0050, 2'b11, 16'hCAFE);
    budget = 20;
    while (!c_rsp_valid && budget > 0) begin
      @(negedge mclk);
      budget--;
    end
    check("bp rsp arrives", c_rsp_valid, 1);
`ifndef PERIPHERAL_MSI_MASTER_FIFO_EN
    req_addr = 14'h0051; req_we = 2'b11; req_wdata = 16'hF00D; req_valid = 1'b1;
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge mclk);
      check("bp rsp_valid held", c_rsp_valid, 1);
      check("bp rsp_write held", c_rsp_write, 1);
      check("bp rsp_rdata held", c_rsp_rdata, 16'h0000);
      check("bp no per_en", c_per_en, 0);
`ifndef PERIPHERAL_MSI_MASTER_FIFO_EN
      check("bp req_ready low", c_req_ready, 0);
`endif
    end
    rsp_ready = 1'b1;
    @(negedge mclk);
    check("bp rsp consumed", c_rsp_valid, 0);
    req_valid = 1'b0;
    $display("[TB] txn bp dut=0 addr=0050 we=11 wdata=cafe -> held 5 cycles");
    tmp = '{1'b0, 14'h0051, 2'b11, 16'hF00D, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    run_txn(100, tmp);

`ifdef PERIPHERAL_MSI_MASTER_FIFO_EN
    // FIFO fill: 6 back-to-back requests with responses stalled
    sel = 1'b0;
    pe_cnt = 0;
    rsp_cnt = 0;
    for (int t = 0; t < 60; t++) begin
      rsp_ready = (t >= 12);
      if (c_per_en) begin
        check("fifo per_addr order", c_per_addr, 14'(14'h0300 + pe_cnt));
        check("fifo per_din order", c_per_din, 16'(16'h5A00 + pe_cnt));
        pe_cnt++;
      end
      if (c_rsp_valid && rsp_ready) begin
        check("fifo rsp_write", c_rsp_write, 1);
        $display("[TB] txn fifo rsp %0d write=%0d", rsp_cnt, c_rsp_write);
        rsp_cnt++;
      end
      if (t < 6) begin
        req_addr = 14'(14'h0300 + t); req_we = 2'b11; req_wdata = 16'(16'h5A00 + t);
        req_valid = 1'b1;
        check("fifo req_ready", c_req_ready, (t < 5) ? 1 : 0);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge mclk);
    end
    check("fifo accesses", pe_cnt, 5);
    check("fifo responses", rsp_cnt, 5);
    check("fifo drained busy", c_busy, 0);
`endif

    // Reset during WAIT
    sel = 1'b1;
    rsp_ready = 1'b1;
    per_dout = 16'h4444;
    push_only(14'h0200, 2'b00, 16'h0000);
`ifdef PERIPHERAL_MSI_MASTER_FIFO_EN
    push_only(14'h0201, 2'b11, 16'h1111);
    push_only(14'h0202, 2'b11, 16'h2222);
`else
    @(negedge mclk);
`endif
    check("pre-reset in wait per_en", c_per_en, 0);
    check("pre-reset busy", c_busy, 1);
    check("pre-reset per_addr", c_per_addr, 14'h0200);
    puc_rst = 1'b1;
    #1;
    check("abort per_en", c_per_en, 0);
    check("abort per_addr", c_per_addr, 14'h0000);
    check("abort busy", c_busy, 0);
    check("abort rsp_valid", c_rsp_valid, 0);
    check("abort req_ready", c_req_ready, 0);
    repeat (2) @(negedge mclk);
    puc_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge mclk);
      if (i == 0) begin
        check("post-reset req_ready", c_req_ready, 1);
        check("post-reset busy", c_busy, 0);
      end
      if (c_rsp_valid || c_per_en) seen++;
    end
    check("no rsp after abort", seen, 0);
    $display("[TB] txn reset-abort dut=2 addr=0200 -> dropped");
    tmp = '{1'b1, 14'h0203, 2'b00, 16'h0000, 16'h7777, 16'h8888, 16'h9999, 16'h9999, 1'b0};
    run_txn(200, tmp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
